ace_snoop_responder: RTL and testbench

ACE_SNOOP_RESPONDER -- requirements
Module: ace_snoop_responder

---
 rtl/ace_snoop_responder.sv | 164 ++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_snoop_responder.sv
// ACE snoop responder: accepts one AC snoop at a time, looks the line up and
// answers on CR. When the response carries data, it streams the line on CD.
module ace_snoop_responder #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int CdBeats   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         ac_valid_i,
  output logic                         ac_ready_o,
  input  logic [AddrWidth-1:0]         ac_addr_i,
  input  logic [3:0]                   ac_snoop_i,
  output logic                         cr_valid_o,
  input  logic                         cr_ready_i,
  output logic [4:0]                   cr_resp_o,
  output logic                         cd_valid_o,
  input  logic                         cd_ready_i,
  output logic [DataWidth-1:0]         cd_data_o,
  output logic                         cd_last_o,
  output logic                         lkp_req_o,
  output logic [AddrWidth-1:0]         lkp_addr_o,
  input  logic                         lkp_hit_i,
  input  logic                         lkp_dirty_i,
  input  logic                         lkp_unique_i,
  input  logic [DataWidth*CdBeats-1:0] lkp_line_i,
  output logic                         upd_inv_o,
  output logic                         upd_clean_o,
  output logic [AddrWidth-1:0]         upd_addr_o
);

  localparam int LineW = DataWidth * CdBeats;
  localparam int BeatW = (CdBeats > 1) ? $clog2(CdBeats) : 1;

  localparam logic [3:0] ReadOnce           = 4'b0000;
  localparam logic [3:0] ReadShared         = 4'b0001;
  localparam logic [3:0] ReadClean          = 4'b0010;
  localparam logic [3:0] ReadNotSharedDirty = 4'b0011;
  localparam logic [3:0] ReadUnique         = 4'b0111;
  localparam logic [3:0] CleanShared        = 4'b1000;
  localparam logic [3:0] CleanInvalid       = 4'b1001;
  localparam logic [3:0] MakeInvalid        = 4'b1101;

  typedef enum logic [2:0] {IDLE, LOOKUP, SAMPLE, RESP, DATA} state_t;

  state_t             r_state;
  logic [BeatW-1:0]   r_beat;
  logic [AddrWidth-1:0] r_addr;
  logic [3:0]         r_snoop;
  logic [LineW-1:0]   r_line;
  logic [4:0]         r_resp;
  logic               r_dt;
  logic               r_inv;
  logic               r_clean;

  logic               w_supported;
  logic               w_shared_code;
  logic               w_inv_code;
  logic               w_clean_code;
  logic               w_dt;
  logic [4:0]         w_resp;
  logic               w_inv;
  logic               w_clean;
  logic               w_last;
  logic               w_done;
  logic [DataWidth-1:0] w_beat_data;

  // Classify the captured snoop and build the response from the lookup result.
  always_comb begin
    w_supported   = 1'b0;
    w_shared_code = 1'b0;
    w_inv_code    = 1'b0;
    w_clean_code  = 1'b0;
    case (r_snoop)
      ReadOnce:                          begin w_supported = 1'b1; w_shared_code = 1'b1; end
      ReadShared, ReadClean,
      ReadNotSharedDirty, CleanShared:   begin w_supported = 1'b1; w_shared_code = 1'b1;
                                               w_clean_code = 1'b1; end
      ReadUnique, CleanInvalid,
      MakeInvalid:                       begin w_supported = 1'b1; w_inv_code = 1'b1; end
      default: ;
    endcase

    if (r_snoop == MakeInvalid)
      w_dt = 1'b0;
    else if (r_snoop == CleanShared || r_snoop == CleanInvalid)
      w_dt = lkp_hit_i && lkp_dirty_i;
    else
      w_dt = lkp_hit_i;

    w_resp  = 5'b00000;
    w_inv   = 1'b0;
    w_clean = 1'b0;
    if (!w_supported) begin
      w_resp = 5'b00010;
      w_dt   = 1'b0;
    end else if (!lkp_hit_i) begin
      w_dt = 1'b0;
    end else begin
      w_resp  = {lkp_unique_i, w_shared_code,
                 lkp_dirty_i && w_dt && (r_snoop != ReadOnce), 1'b0, w_dt};
      w_inv   = w_inv_code;
      w_clean = w_clean_code && lkp_dirty_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_beat  <= '0;
    end else begin
      case (r_state)
        IDLE: if (ac_valid_i) begin
          r_addr  <= ac_addr_i;
          r_snoop <= ac_snoop_i;
          r_state <= LOOKUP;
        end
        LOOKUP: r_state <= SAMPLE;
        SAMPLE: begin
          r_resp  <= w_resp;
          r_dt    <= w_dt;
          r_inv   <= w_inv;
          r_clean <= w_clean;
          r_line  <= lkp_line_i;
          r_state <= RESP;
        end
        RESP: if (cr_ready_i) begin
          r_beat  <= '0;
          r_state <= r_dt ? DATA : IDLE;
        end
        DATA: if (cd_ready_i) begin
          if (w_last) begin
            r_beat  <= '0;
            r_state <= IDLE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_last      = (r_beat == BeatW'(CdBeats - 1));
  assign w_beat_data = r_line[int'(r_beat) * DataWidth +: DataWidth];

  // The final handshake is the CR one for data-less snoops, else the last CD beat.
  assign w_done = !rst_i &&
                  (((r_state == RESP) && cr_ready_i && !r_dt) ||
                   ((r_state == DATA) && cd_ready_i && w_last));

  assign ac_ready_o  = !rst_i && (r_state == IDLE);
  assign lkp_req_o   = !rst_i && (r_state == LOOKUP);
  assign lkp_addr_o  = (r_state == LOOKUP) ? r_addr : '0;
  assign cr_valid_o  = !rst_i && (r_state == RESP);
  assign cr_resp_o   = (r_state == RESP) ? r_resp : 5'b00000;
  assign cd_valid_o  = !rst_i && (r_state == DATA);
  assign cd_data_o   = (r_state == DATA) ? w_beat_data : '0;
  assign cd_last_o   = (r_state == DATA) && w_last;
  assign upd_inv_o   = w_done && r_inv;
  assign upd_clean_o = w_done && r_clean && !r_inv;
  assign upd_addr_o  = (r_state == RESP || r_state == DATA) ? r_addr : '0;

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Directed bench for ace_snoop_responder: each task drives one snoop scenario
// and compares outputs against hand-computed values at the falling edge.
module tb_ace_snoop_responder;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int NB = 4;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            ac_valid_i;
  logic            ac_ready_o;
  logic [AW-1:0]   ac_addr_i;
  logic [3:0]      ac_snoop_i;
  logic            cr_valid_o;
  logic            cr_ready_i;
  logic [4:0]      cr_resp_o;
  logic            cd_valid_o;
  logic            cd_ready_i;
  logic [DW-1:0]   cd_data_o;
  logic            cd_last_o;
  logic            lkp_req_o;
  logic [AW-1:0]   lkp_addr_o;
  logic            lkp_hit_i;
  logic            lkp_dirty_i;
  logic            lkp_unique_i;
  logic [DW*NB-1:0] lkp_line_i;
  logic            upd_inv_o;
  logic            upd_clean_o;
  logic [AW-1:0]   upd_addr_o;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] beatVals [NB];

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .CdBeats(NB)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ac_valid_i(ac_valid_i), .ac_ready_o(ac_ready_o),
    .ac_addr_i(ac_addr_i), .ac_snoop_i(ac_snoop_i),
    .cr_valid_o(cr_valid_o), .cr_ready_i(cr_ready_i), .cr_resp_o(cr_resp_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i),
    .cd_data_o(cd_data_o), .cd_last_o(cd_last_o),
    .lkp_req_o(lkp_req_o), .lkp_addr_o(lkp_addr_o),
    .lkp_hit_i(lkp_hit_i), .lkp_dirty_i(lkp_dirty_i),
    .lkp_unique_i(lkp_unique_i), .lkp_line_i(lkp_line_i),
    .upd_inv_o(upd_inv_o), .upd_clean_o(upd_clean_o), .upd_addr_o(upd_addr_o)
  );

  always #5 clk_i = ~clk_i;

  // Builds a recognisable line whose beats are base, base+0x0101, ...
  task automatic load_line(input logic [DW-1:0] base);
    for (int k = 0; k < NB; k++) begin
      beatVals[k] = base + DW'(k * 32'h0101);
      lkp_line_i[k*DW +: DW] = beatVals[k];
    end
  endtask

  // Presents one AC request for a cycle; returns at the falling edge after it.
  task automatic send_ac(input logic [AW-1:0] addr, input logic [3:0] snoop);
    @(negedge clk_i);
    ac_valid_i = 1'b1;
    ac_addr_i  = addr;
    ac_snoop_i = snoop;
    @(negedge clk_i);
    ac_valid_i = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (ac_ready_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_ac_ready: got %b expected 0", ac_ready_o); end
    checks++;
    if ({cr_valid_o, cd_valid_o, lkp_req_o, upd_inv_o, upd_clean_o} !== 5'b0) begin
      errors++; $display("[TB] FAIL rst_valids: got %b expected 00000",
                         {cr_valid_o, cd_valid_o, lkp_req_o, upd_inv_o, upd_clean_o});
    end
    rst_i = 1'b0;
    @(negedge clk_i); #1;
    checks++;
    if (ac_ready_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_ready: got %b expected 1", ac_ready_o); end
  endtask

  task automatic test_read_shared_hit;
    logic [AW-1:0] addr = 64'h0000_1234_5678_9A40;
    load_line(64'hA5A5_0000_0000_1000);
    lkp_hit_i = 1'b1; lkp_dirty_i = 1'b1; lkp_unique_i = 1'b1;
    cr_ready_i = 1'b1; cd_ready_i = 1'b1;
    send_ac(addr, 4'b0001);
    #1;
    checks++;
    if (lkp_req_o !== 1'b1 || lkp_addr_o !== addr) begin
      errors++; $display("[TB] FAIL rs_lookup: got req=%b addr=%h expected req=1 addr=%h", lkp_req_o, lkp_addr_o, addr);
    end
    @(negedge clk_i); #1;
    checks++;
    if (lkp_req_o !== 1'b0 || cr_valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rs_sample: got req=%b crv=%b expected 0 0", lkp_req_o, cr_valid_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b11101 || upd_clean_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rs_resp: got v=%b resp=%b upd=%b expected v=1 resp=11101 upd=0",
                         cr_valid_o, cr_resp_o, upd_clean_o);
    end
    for (int k = 0; k < NB; k++) begin
      @(negedge clk_i); #1;
      checks++;
      if (cd_valid_o !== 1'b1 || cr_valid_o !== 1'b0 || cd_data_o !== beatVals[k] ||
          cd_last_o !== (k == NB-1) || upd_clean_o !== (k == NB-1) || upd_inv_o !== 1'b0) begin
        errors++; $display("[TB] FAIL rs_beat%0d: got v=%b crv=%b data=%h last=%b clean=%b inv=%b expected data=%h last=%b",
                           k, cd_valid_o, cr_valid_o, cd_data_o, cd_last_o, upd_clean_o, upd_inv_o,
                           beatVals[k], (k == NB-1));
      end
      if (k == NB-1) begin
        checks++;
        if (upd_addr_o !== addr) begin errors++; $display("[TB] FAIL rs_upd_addr: got %h expected %h", upd_addr_o, addr); end
      end
    end
    @(negedge clk_i); #1;
    checks++;
    if (cd_valid_o !== 1'b0 || upd_clean_o !== 1'b0 || ac_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rs_done: got cdv=%b clean=%b ready=%b expected 0 0 1", cd_valid_o, upd_clean_o, ac_ready_o);
    end
  endtask

  task automatic test_read_unique_miss;
    lkp_hit_i = 1'b0; lkp_dirty_i = 1'b1; lkp_unique_i = 1'b1;
    cr_ready_i = 1'b1; cd_ready_i = 1'b1;
    send_ac(64'h0000_0000_0000_0080, 4'b0111);
    @(negedge clk_i); #1;
    checks++;
    if (cr_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ru_early_cr: got %b expected 0", cr_valid_o); end
    @(negedge clk_i); #1;
    checks++;
    if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b00000 || upd_inv_o !== 1'b0 || upd_clean_o !== 1'b0) begin
      errors++; $display("[TB] FAIL ru_resp: got v=%b resp=%b inv=%b clean=%b expected 1 00000 0 0",
                         cr_valid_o, cr_resp_o, upd_inv_o, upd_clean_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (ac_ready_o !== 1'b1 || cd_valid_o !== 1'b0 || cr_valid_o !== 1'b0) begin
      errors++; $display("[TB] FAIL ru_after: got ready=%b cdv=%b crv=%b expected 1 0 0", ac_ready_o, cd_valid_o, cr_valid_o);
    end
  endtask

  task automatic test_make_invalid;
    logic [AW-1:0] addr = 64'h0000_0000_0000_0F00;
    lkp_hit_i = 1'b1; lkp_dirty_i = 1'b1; lkp_unique_i = 1'b1;
    cr_ready_i = 1'b1; cd_ready_i = 1'b1;
    send_ac(addr, 4'b1101);
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b10000 || upd_inv_o !== 1'b1 ||
        upd_clean_o !== 1'b0 || upd_addr_o !== addr) begin
      errors++; $display("[TB] FAIL mi_resp: got v=%b resp=%b inv=%b clean=%b addr=%h expected 1 10000 1 0 %h",
                         cr_valid_o, cr_resp_o, upd_inv_o, upd_clean_o, upd_addr_o, addr);
    end
    @(negedge clk_i); #1;
    checks++;
    if (cd_valid_o !== 1'b0 || upd_inv_o !== 1'b0 || ac_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL mi_after: got cdv=%b inv=%b ready=%b expected 0 0 1", cd_valid_o, upd_inv_o, ac_ready_o);
    end
  endtask

  task automatic test_unsupported;
    lkp_hit_i = 1'b1; lkp_dirty_i = 1'b1; lkp_unique_i = 1'b1;
    cr_ready_i = 1'b1; cd_ready_i = 1'b1;
    send_ac(64'h0000_0000_0000_1100, 4'b0101);
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b00010 || upd_inv_o !== 1'b0 || upd_clean_o !== 1'b0) begin
      errors++; $display("[TB] FAIL un_resp: got v=%b resp=%b inv=%b clean=%b expected 1 00010 0 0",
                         cr_valid_o, cr_resp_o, upd_inv_o, upd_clean_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (cd_valid_o !== 1'b0 || ac_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL un_after: got cdv=%b ready=%b expected 0 1", cd_valid_o, ac_ready_o);
    end
  endtask

  task automatic test_stall_clean_invalid;
    int k = 0;
    int invCount = 0;
    int cyc = 0;
    logic toggle = 1'b0;
    load_line(64'h5A5A_0000_0000_2000);
    lkp_hit_i = 1'b1; lkp_dirty_i = 1'b1; lkp_unique_i = 1'b0;
    cr_ready_i = 1'b0; cd_ready_i = 1'b0;
    send_ac(64'h0000_0000_0000_2240, 4'b1001);
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      checks++;
      if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b00101 || cd_valid_o !== 1'b0 || upd_inv_o !== 1'b0) begin
        errors++; $display("[TB] FAIL st_cr_hold%0d: got v=%b resp=%b cdv=%b inv=%b expected 1 00101 0 0",
                           i, cr_valid_o, cr_resp_o, cd_valid_o, upd_inv_o);
      end
    end
    @(negedge clk_i);
    cr_ready_i = 1'b1;
    #1;
    checks++;
    if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b00101 || upd_inv_o !== 1'b0) begin
      errors++; $display("[TB] FAIL st_cr_hs: got v=%b resp=%b inv=%b expected 1 00101 0", cr_valid_o, cr_resp_o, upd_inv_o);
    end
    @(negedge clk_i);
    cr_ready_i = 1'b0;
    while (k < NB && cyc < 40) begin
      cd_ready_i = toggle;
      #1;
      checks++;
      if (cd_valid_o !== 1'b1 || cr_valid_o !== 1'b0 || cd_data_o !== beatVals[k] ||
          cd_last_o !== (k == NB-1) || upd_inv_o !== (toggle && k == NB-1)) begin
        errors++; $display("[TB] FAIL st_beat%0d_cyc%0d: got v=%b crv=%b data=%h last=%b inv=%b expected data=%h last=%b",
                           k, cyc, cd_valid_o, cr_valid_o, cd_data_o, cd_last_o, upd_inv_o, beatVals[k], (k == NB-1));
      end
      if (upd_inv_o === 1'b1) invCount++;
      if (toggle) k++;
      toggle = ~toggle;
      cyc++;
      @(negedge clk_i);
    end
    cd_ready_i = 1'b0;
    #1;
    checks++;
    if (k != NB) begin errors++; $display("[TB] FAIL st_beat_count: got %0d expected %0d", k, NB); end
    checks++;
    if (invCount != 1) begin errors++; $display("[TB] FAIL st_inv_count: got %0d expected 1", invCount); end
    checks++;
    if (cd_valid_o !== 1'b0 || upd_inv_o !== 1'b0 || ac_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL st_after: got cdv=%b inv=%b ready=%b expected 0 0 1", cd_valid_o, upd_inv_o, ac_ready_o);
    end
  endtask

  task automatic test_reset_mid_data;
    load_line(64'h0F0F_0000_0000_3000);
    lkp_hit_i = 1'b1; lkp_dirty_i = 1'b0; lkp_unique_i = 1'b0;
    cr_ready_i = 1'b1; cd_ready_i = 1'b1;
    send_ac(64'h0000_0000_0000_3300, 4'b0000);
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b01001) begin
      errors++; $display("[TB] FAIL rm_resp: got v=%b resp=%b expected 1 01001", cr_valid_o, cr_resp_o);
    end
    repeat (3) @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++;
    if (upd_inv_o !== 1'b0 || upd_clean_o !== 1'b0) begin
      errors++; $display("[TB] FAIL rm_pulse_rst: got inv=%b clean=%b expected 0 0", upd_inv_o, upd_clean_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if ({cr_valid_o, cd_valid_o, lkp_req_o, upd_inv_o, upd_clean_o, ac_ready_o} !== 6'b0) begin
      errors++; $display("[TB] FAIL rm_after_rst: got %b expected 000000",
                         {cr_valid_o, cd_valid_o, lkp_req_o, upd_inv_o, upd_clean_o, ac_ready_o});
    end
    rst_i = 1'b0;
    load_line(64'hC3C3_0000_0000_4000);
    lkp_dirty_i = 1'b1;
    send_ac(64'h0000_0000_0000_4400, 4'b0010);
    repeat (2) @(negedge clk_i);
    #1;
    checks++;
    if (cr_valid_o !== 1'b1 || cr_resp_o !== 5'b01101) begin
      errors++; $display("[TB] FAIL rm_next_resp: got v=%b resp=%b expected 1 01101", cr_valid_o, cr_resp_o);
    end
    for (int k = 0; k < NB; k++) begin
      @(negedge clk_i); #1;
      checks++;
      if (cd_valid_o !== 1'b1 || cd_data_o !== beatVals[k] || cd_last_o !== (k == NB-1) ||
          upd_clean_o !== (k == NB-1)) begin
        errors++; $display("[TB] FAIL rm_next_beat%0d: got v=%b data=%h last=%b clean=%b expected data=%h last=%b",
                           k, cd_valid_o, cd_data_o, cd_last_o, upd_clean_o, beatVals[k], (k == NB-1));
      end
    end
    @(negedge clk_i); #1;
    checks++;
    if (cd_valid_o !== 1'b0 || ac_ready_o !== 1'b1) begin
      errors++; $display("[TB] FAIL rm_next_done: got cdv=%b ready=%b expected 0 1", cd_valid_o, ac_ready_o);
    end
  endtask

  initial begin
    rst_i = 1'b1;
    ac_valid_i = 1'b0; ac_addr_i = '0; ac_snoop_i = 4'b0000;
    cr_ready_i = 1'b0; cd_ready_i = 1'b0;
    lkp_hit_i = 1'b0; lkp_dirty_i = 1'b0; lkp_unique_i = 1'b0; lkp_line_i = '0;
    test_reset();
    test_read_shared_hit();
    test_read_unique_miss();
    test_make_invalid();
    test_unsupported();
    test_stall_clean_invalid();
    test_reset_mid_data();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
